// File: rtl/fifo_wr_traffic_gen.sv
// Write-side FIFO traffic source: bursts of a wrapping pattern, gaps, stall count.
// Define PRBS_PATTERN_EN to source data from an 8-bit LFSR instead.
module fifo_wr_traffic_gen #(
    parameter int DATA_W      = 8,
    parameter int PATTERN_LEN = 64,
    parameter int BURST_LEN   = 16,
    parameter int GAP_CYCLES  = 4,
    parameter int CNT_W       = 16
) (
    input  logic              w_clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic [CNT_W-1:0]  num_words,
    input  logic              full,
    output logic              w_en,
    output logic [DATA_W-1:0] d_in,
    output logic              busy,
    output logic              done,
    output logic [CNT_W-1:0]  words_sent,
    output logic [CNT_W-1:0]  stall_cnt
);

    localparam int BCNT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam int GCNT_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    localparam logic [BCNT_W-1:0] BCNT_LAST = BCNT_W'(BURST_LEN - 1);
    localparam logic [GCNT_W-1:0] GCNT_LOAD =
        GCNT_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

    typedef enum logic [1:0] {
        S_IDLE,
        S_BURST,
        S_GAP,
        S_DONE
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   num_q, num_d;
    logic [CNT_W-1:0]   sent_q, sent_d;
    logic [CNT_W-1:0]   stall_q, stall_d;
    logic [BCNT_W-1:0]  bcnt_q, bcnt_d;
    logic [GCNT_W-1:0]  gcnt_q, gcnt_d;

    assign words_sent = sent_q;
    assign stall_cnt  = stall_q;

    always_comb begin
        state_d = state_q;
        num_d   = num_q;
        sent_d  = sent_q;
        stall_d = stall_q;
        bcnt_d  = bcnt_q;
        gcnt_d  = gcnt_q;
        w_en    = 1'b0;
        done    = 1'b0;
        busy    = (state_q == S_BURST) || (state_q == S_GAP);

        // abort wins over start, completion and the done pulse
        if (abort) begin
            state_d = S_IDLE;
        end else begin
            unique case (1'b1)
                state_q == S_IDLE: begin
                    if (start) begin
                        if (num_words != '0) begin
                            num_d   = num_words;
                            sent_d  = '0;
                            stall_d = '0;
                            bcnt_d  = '0;
                            state_d = S_BURST;
                        end else begin
                            state_d = S_DONE;
                        end
                    end
                end
                state_q == S_BURST: begin
                    if (full) begin
                        if (stall_q != '1) begin
                            stall_d = stall_q + 1'b1;
                        end
                    end else begin
                        w_en   = 1'b1;
                        sent_d = sent_q + 1'b1;
                        bcnt_d = (bcnt_q == BCNT_LAST) ? '0 : bcnt_q + 1'b1;
                        if (sent_d == num_q) begin
                            state_d = S_DONE;
                        end else if (bcnt_q == BCNT_LAST && GAP_CYCLES > 0) begin
                            gcnt_d  = GCNT_LOAD;
                            state_d = S_GAP;
                        end
                    end
                end
                state_q == S_GAP: begin
                    if (gcnt_q == '0) begin
                        state_d = S_BURST;
                    end else begin
                        gcnt_d = gcnt_q - 1'b1;
                    end
                end
                state_q == S_DONE: begin
                    done    = 1'b1;
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge w_clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            num_q   <= '0;
            sent_q  <= '0;
            stall_q <= '0;
            bcnt_q  <= '0;
            gcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            num_q   <= num_d;
            sent_q  <= sent_d;
            stall_q <= stall_d;
            bcnt_q  <= bcnt_d;
            gcnt_q  <= gcnt_d;
        end
    end

`ifdef PRBS_PATTERN_EN
    // x^8+x^6+x^5+x^4+1, advanced only by accepted writes
    logic [7:0] lfsr_q;
    logic       lfsr_fb;

    assign lfsr_fb = lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3];
    assign d_in    = DATA_W'(lfsr_q);

    always_ff @(posedge w_clk) begin
        if (rst) begin
            lfsr_q <= 8'h01;
        end else if (w_en) begin
            lfsr_q <= {lfsr_q[6:0], lfsr_fb};
        end
    end
`else
    localparam logic [DATA_W-1:0] PAT_LAST = DATA_W'(PATTERN_LEN - 1);

    logic [DATA_W-1:0] pat_q;

    assign d_in = pat_q;

    always_ff @(posedge w_clk) begin
        if (rst) begin
            pat_q <= '0;
        end else if (w_en) begin
            pat_q <= (pat_q == PAT_LAST) ? '0 : pat_q + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_fifo_wr_traffic_gen.sv
// Bench for fifo_wr_traffic_gen: transaction-level model checked every cycle,
// directed scenarios with literal pins, then randomized traffic.
module tb_fifo_wr_traffic_gen;

    localparam int DATA_W      = 8;
    localparam int PATTERN_LEN = 64;
    localparam int BURST_LEN   = 16;
    localparam int GAP_CYCLES  = 4;
    localparam int CNT_W       = 16;

    localparam int M_IDLE = 0;
    localparam int M_RUN  = 1;
    localparam int M_GAP  = 2;
    localparam int M_DONE = 3;

    logic              w_clk = 1'b0;
    logic              rst = 1'b1;
    logic              start = 1'b0;
    logic              abort = 1'b0;
    logic [CNT_W-1:0]  num_words = '0;
    logic              full = 1'b0;
    logic              w_en;
    logic [DATA_W-1:0] d_in;
    logic              busy;
    logic              done;
    logic [CNT_W-1:0]  words_sent;
    logic [CNT_W-1:0]  stall_cnt;

    fifo_wr_traffic_gen #(
        .DATA_W(DATA_W),
        .PATTERN_LEN(PATTERN_LEN),
        .BURST_LEN(BURST_LEN),
        .GAP_CYCLES(GAP_CYCLES),
        .CNT_W(CNT_W)
    ) dut (
        .w_clk(w_clk),
        .rst(rst),
        .start(start),
        .abort(abort),
        .num_words(num_words),
        .full(full),
        .w_en(w_en),
        .d_in(d_in),
        .busy(busy),
        .done(done),
        .words_sent(words_sent),
        .stall_cnt(stall_cnt)
    );

    always #5 w_clk = ~w_clk;

    int errs = 0;
    int checks = 0;
    int cyc = 0;
    int done_cnt = 0;
    int acc_d[$];
    int acc_c[$];

    int m_mode = M_IDLE;
    int m_num = 0;
    int m_sent = 0;
    int m_stall = 0;
    int m_gap = 0;
    int m_total = 0;
    logic [7:0] m_lfsr = 8'h01;
    bit m_valid = 1'b0;

    task automatic chk(string name, longint got, longint exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s at cycle %0d: got %0d expected %0d",
                     name, cyc, got, exp);
        end
    endtask

    function automatic logic [7:0] lfsr_step(logic [7:0] v);
        return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
    endfunction

    // k-th accepted word since reset
    function automatic int ref_word(int k);
        logic [7:0] v;
`ifdef PRBS_PATTERN_EN
        v = 8'h01;
        for (int i = 0; i < k; i++) v = lfsr_step(v);
        return int'(v);
`else
        v = 8'h00;
        return k % PATTERN_LEN + int'(v);
`endif
    endfunction

    // hand-computed literal in incrementing mode, reference LFSR otherwise
    function automatic int lit(int k, int inc_val);
`ifdef PRBS_PATTERN_EN
        return ref_word(k) + 0 * inc_val;
`else
        return inc_val + 0 * k;
`endif
    endfunction

    function automatic int exp_din();
`ifdef PRBS_PATTERN_EN
        return int'(m_lfsr);
`else
        return m_total % PATTERN_LEN;
`endif
    endfunction

    function automatic int get(int i);
        if (i < acc_d.size()) return acc_d[i];
        return -1;
    endfunction

    always @(posedge w_clk) cyc <= cyc + 1;

    always @(negedge w_clk) begin
        if (m_valid) begin
            chk("w_en", w_en, longint'(m_mode == M_RUN && !full && !abort));
            chk("d_in", d_in, exp_din());
            chk("busy", busy, longint'(m_mode == M_RUN || m_mode == M_GAP));
            chk("done", done, longint'(m_mode == M_DONE && !abort));
            chk("words_sent", words_sent, m_sent);
            chk("stall_cnt", stall_cnt, m_stall);
            if (w_en) begin
                acc_d.push_back(int'(d_in));
                acc_c.push_back(cyc);
            end
            if (done) done_cnt++;
        end
        if (rst) begin
            m_mode = M_IDLE;
            m_num = 0;
            m_sent = 0;
            m_stall = 0;
            m_gap = 0;
            m_total = 0;
            m_lfsr = 8'h01;
            m_valid = 1'b1;
        end else if (abort) begin
            m_mode = M_IDLE;
        end else begin
            case (m_mode)
                M_IDLE: if (start) begin
                    if (num_words != 0) begin
                        m_num = int'(num_words);
                        m_sent = 0;
                        m_stall = 0;
                        m_mode = M_RUN;
                    end else begin
                        m_mode = M_DONE;
                    end
                end
                M_RUN: if (!full) begin
                    m_total++;
                    m_sent++;
                    m_lfsr = lfsr_step(m_lfsr);
                    if (m_sent == m_num) m_mode = M_DONE;
                    else if (m_sent % BURST_LEN == 0 && GAP_CYCLES > 0) begin
                        m_mode = M_GAP;
                        m_gap = GAP_CYCLES;
                    end
                end else if (m_stall < (1 << CNT_W) - 1) begin
                    m_stall++;
                end
                M_GAP: begin
                    m_gap--;
                    if (m_gap == 0) m_mode = M_RUN;
                end
                default: m_mode = M_IDLE;
            endcase
        end
    end

    task automatic step(bit s, bit a, int n, bit f);
        start = s;
        abort = a;
        num_words = CNT_W'(n);
        full = f;
        @(posedge w_clk);
        #1;
    endtask

    task automatic idle(int k);
        repeat (k) step(0, 0, 0, 0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle(2);
        rst = 1'b0;
        acc_d.delete();
        acc_c.delete();
    endtask

    task automatic wait_acc(int n, bit f, int budget);
        int k = 0;
        while (acc_d.size() < n && k < budget) begin
            step(0, 0, 0, f);
            k++;
        end
        chk("wait_acc_timeout", longint'(acc_d.size() >= n), 1);
    endtask

    task automatic wait_idle(int budget);
        int k = 0;
        while ((busy || done) && k < budget) begin
            step(0, 0, 0, 0);
            k++;
        end
        chk("wait_idle_timeout", busy, 0);
    endtask

    initial begin
        int d0;
        int n0;
        do_reset();
        chk("rst_w_en", w_en, 0);
        chk("rst_d_in", d_in, lit(0, 0));
        chk("rst_words_sent", words_sent, 0);

        // five words, back to back
        d0 = done_cnt;
        step(1, 0, 5, 0);
        wait_idle(50);
        idle(2);
        chk("s1_count", acc_d.size(), 5);
`ifdef PRBS_PATTERN_EN
        chk("s1_prbs0", get(0), 8'h01);
        chk("s1_prbs1", get(1), 8'h02);
        chk("s1_prbs2", get(2), 8'h04);
        chk("s1_prbs3", get(3), 8'h08);
`else
        chk("s1_d0", get(0), 0);
        chk("s1_d4", get(4), 4);
`endif
        chk("s1_consecutive", acc_c.size() == 5 ? acc_c[4] - acc_c[0] : -1, 4);
        chk("s1_done_cnt", done_cnt - d0, 1);
        chk("s1_words_sent", words_sent, 5);

        // 70 words: bursts, gaps, wrap; then a 3-word continuation
        do_reset();
        step(1, 0, 70, 0);
        wait_idle(300);
        chk("s2_count", acc_d.size(), 70);
        chk("s2_d15", get(15), lit(15, 15));
        chk("s2_d16", get(16), lit(16, 16));
        chk("s2_gap", acc_c.size() > 16 ? acc_c[16] - acc_c[15] : -1, 5);
        chk("s2_d63", get(63), lit(63, 63));
        chk("s2_d64", get(64), lit(64, 0));
        chk("s2_d69", get(69), lit(69, 5));
        step(1, 0, 3, 0);
        wait_idle(50);
        chk("s2_next0", get(70), lit(70, 6));
        chk("s2_next2", get(72), lit(72, 8));

        // full held for 7 cycles after the 3rd write
        do_reset();
        step(1, 0, 10, 0);
        wait_acc(3, 0, 20);
        repeat (7) step(0, 0, 0, 1);
        wait_idle(50);
        chk("s3_count", acc_d.size(), 10);
        for (int i = 0; i < 10; i++) chk("s3_data", get(i), lit(i, i));
        chk("s3_stall_cnt", stall_cnt, 7);

        // abort after 4 writes
        do_reset();
        d0 = done_cnt;
        step(1, 0, 20, 0);
        wait_acc(4, 0, 20);
        step(0, 1, 0, 0);
        idle(3);
        chk("s4_count", acc_d.size(), 4);
        chk("s4_words_sent", words_sent, 4);
        chk("s4_no_done", done_cnt - d0, 0);
        step(1, 0, 3, 0);
        wait_idle(50);
        chk("s4_resume", get(4), lit(4, 4));
        chk("s4_resume2", get(6), lit(6, 6));

        // zero-length start, then start while busy
        d0 = done_cnt;
        n0 = acc_d.size();
        step(1, 0, 0, 0);
        chk("s5_done_now", done, 1);
        idle(2);
        chk("s5_done_cnt", done_cnt - d0, 1);
        chk("s5_no_write", acc_d.size(), n0);
        step(1, 0, 5, 0);
        step(1, 0, 99, 0);
        wait_idle(50);
        chk("s5_ignored_start", acc_d.size() - n0, 5);
        chk("s5_words_sent", words_sent, 5);

        // randomized traffic with one mid-run reset
        for (int i = 0; i < 600; i++) begin
            if (i == 300) do_reset();
            step($urandom_range(0, 7) == 0, $urandom_range(0, 59) == 0,
                 $urandom_range(0, 40), $urandom_range(0, 3) == 0);
        end
        wait_idle(500);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errs);
        $fatal(1);
    end

endmodule
